// File: rtl/round_pkg.sv
// Shared rounding-mode encodings and precision-dependent width helpers.
package round_pkg;

    typedef enum logic [1:0] {
        RM_ZERO      = 2'b00,
        RM_POS_INF   = 2'b01,
        RM_NEG_INF   = 2'b10,
        RM_NEAR_EVEN = 2'b11
    } round_mode_e;

    function automatic int unsigned dout_w(int unsigned is_double);
        return (is_double != 0) ? 53 : 24;
    endfunction

    // Products carry twice the result width; the low half is rounded away.
    function automatic int unsigned din_w(int unsigned is_double);
        return 2 * dout_w(is_double);
    endfunction

endpackage

// File: rtl/rounding_module.sv
// Rounds an unsigned double-width product to its upper half; one registered cycle of latency.
module rounding_module
    import round_pkg::*;
#(
    parameter int unsigned  IS_DOUBLE = 0,
    localparam int unsigned DinW      = din_w(IS_DOUBLE),
    localparam int unsigned DoutW     = dout_w(IS_DOUBLE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DinW-1:0]  din_i,
    input  logic [1:0]       mode_i,
    output logic [DoutW-1:0] dout_o,
    output logic             exact_o
);

    logic [DoutW-1:0] hi, lo, dout_d, dout_q;
    logic             guard, sticky, inexact, round_up, exact_q;

    assign hi      = din_i[DinW-1:DoutW];
    assign lo      = din_i[DoutW-1:0];
    assign guard   = lo[DoutW-1];
    assign sticky  = |lo[DoutW-2:0];
    assign inexact = guard | sticky;

    always_comb begin
        round_up = 1'b0;
        unique case (mode_i)
            RM_ZERO, RM_NEG_INF: round_up = 1'b0;
            RM_POS_INF:          round_up = inexact;
            // Exact tie goes to the even neighbour.
            RM_NEAR_EVEN:        round_up = guard & (sticky | hi[0]);
            default:             round_up = 1'b0;
        endcase
    end

    assign dout_d = hi + DoutW'(round_up);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q  <= '0;
            exact_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            exact_q <= ~inexact;
        end
    end

    assign dout_o  = dout_q;
    assign exact_o = exact_q;

endmodule

// File: rtl/round_arbiter.sv
// Round-robin arbiter sharing one rounding unit among N_REQ requesters,
// with a 2-entry result buffer and credit-based issue control.
module round_arbiter
    import round_pkg::*;
#(
    parameter int unsigned  IS_DOUBLE = 0,
    parameter int unsigned  N_REQ     = 4,
    localparam int unsigned DIN_W     = din_w(IS_DOUBLE),
    localparam int unsigned DOUT_W    = dout_w(IS_DOUBLE),
    localparam int unsigned TAG_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    input  logic [N_REQ*2-1:0]     req_mode,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [TAG_W-1:0]       res_tag,
    output logic [DOUT_W-1:0]      res_data,
    output logic                   res_acc,
    output logic                   busy
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DOUT_W-1:0] data;
        logic              acc;
    } res_entry_t;

    logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d, tag_q, gnt_idx, idx;
    logic [TAG_W:0]    sum;
    logic              inflight_q, wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d, occ;
    logic              pop, push, credit, gnt_found, xfer;
    logic [DIN_W-1:0]  rnd_din;
    logic [1:0]        rnd_mode;
    logic [DOUT_W-1:0] rnd_dout;
    logic              rnd_exact;
    res_entry_t        fifo_q [2];
    res_entry_t        head;

    assign res_valid = (cnt_q != 2'd0);
    assign pop       = res_valid & res_ready;
    assign push      = inflight_q;
    assign occ       = {1'b0, inflight_q} + cnt_q;
    assign credit    = (occ - {1'b0, pop}) < 2'd2;
    assign busy      = (occ != 2'd0);

    // First asserted request at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            if (sum >= (TAG_W+1)'(N_REQ)) begin
                sum = sum - (TAG_W+1)'(N_REQ);
            end
            idx = sum[TAG_W-1:0];
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Gated by rst so req_ready drops immediately on reset assertion.
    assign xfer = rst & credit & gnt_found;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rnd_din  = xfer ? req_data[gnt_idx*DIN_W +: DIN_W] : '0;
    assign rnd_mode = xfer ? req_mode[gnt_idx*2 +: 2] : 2'b00;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= xfer;
            tag_q      <= gnt_idx;
            cnt_q      <= cnt_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{tag: tag_q, data: rnd_dout, acc: rnd_exact};
        end
    end

    rounding_module #(
        .IS_DOUBLE(IS_DOUBLE)
    ) u_round (
        .clk_i  (clk),
        .rst_i  (~rst),
        .din_i  (rnd_din),
        .mode_i (rnd_mode),
        .dout_o (rnd_dout),
        .exact_o(rnd_exact)
    );

    // Buffer storage is not reset, so the head is masked when empty.
    assign head     = fifo_q[rd_ptr_q];
    assign res_tag  = res_valid ? head.tag  : '0;
    assign res_data = res_valid ? head.data : '0;
    assign res_acc  = res_valid ? head.acc  : 1'b0;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed and randomized bench for round_arbiter against a queue-based reference model.
module tb_round_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready;
    logic [191:0] req_data;
    logic [7:0]   req_mode;
    logic         res_valid, res_ready, res_acc, busy;
    logic [1:0]   res_tag;
    logic [23:0]  res_data;

    logic [47:0]  din  [4];
    logic [1:0]   mode [4];

    typedef struct {
        int          tag;
        logic [23:0] data;
        logic        acc;
        int          avail;
    } item_t;

    item_t       pend[$];
    int          rr, cyc;
    int          n_pass, n_total, n_fail;
    logic [3:0]  obs_ready;
    logic        obs_rv, obs_acc;
    logic [1:0]  obs_tag;
    logic [23:0] obs_data;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_data[i*48 +: 48] = din[i];
            req_mode[i*2 +: 2]   = mode[i];
        end
    end

    round_arbiter #(
        .IS_DOUBLE(0),
        .N_REQ    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_mode (req_mode),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_tag  (res_tag),
        .res_data (res_data),
        .res_acc  (res_acc),
        .busy     (busy)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rounding computed arithmetically on the integer value of the product.
    function automatic logic [24:0] ref_round(logic [47:0] d, logic [1:0] m);
        longint unsigned x, hi, lo, half, one;
        x    = 64'(d);
        hi   = x / (64'd1 << 24);
        lo   = x % (64'd1 << 24);
        half = 64'd1 << 23;
        one  = 0;
        case (m)
            2'd1:    one = (lo != 0) ? 1 : 0;
            2'd3:    one = ((lo > half) || (lo == half && hi % 2 == 1)) ? 1 : 0;
            default: one = 0;
        endcase
        return {(lo == 0), 24'((hi + one) % (64'd1 << 24))};
    endfunction

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic tick();
        int          grant, sz;
        bit          hv, pop, credit;
        logic [3:0]  exp_ready;
        logic [24:0] r;
        @(negedge clk);
        obs_ready = req_ready;
        obs_rv    = res_valid;
        obs_tag   = res_tag;
        obs_data  = res_data;
        obs_acc   = res_acc;
        grant     = -1;
        pop       = 0;
        if (!rst) begin
            chk("rst_req_ready", 64'(req_ready), 0);
            chk("rst_res_valid", 64'(res_valid), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_res_tag", 64'(res_tag), 0);
            chk("rst_res_data", 64'(res_data), 0);
            chk("rst_res_acc", 64'(res_acc), 0);
        end else begin
            sz = pend.size();
            hv = 0;
            if (sz > 0) hv = (pend[0].avail <= cyc);
            pop    = hv && res_ready;
            credit = (sz - int'(pop)) < 2;
            if (credit) begin
                for (int k = 0; k < N; k++) begin
                    if (grant < 0 && req_valid[(rr + k) % N]) grant = (rr + k) % N;
                end
            end
            exp_ready = (grant >= 0) ? 4'(1 << grant) : 4'b0;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("res_valid", 64'(res_valid), 64'(hv));
            chk("busy", 64'(busy), 64'(sz != 0));
            if (hv) begin
                chk("res_tag", 64'(res_tag), 64'(pend[0].tag));
                chk("res_data", 64'(res_data), 64'(pend[0].data));
                chk("res_acc", 64'(res_acc), 64'(pend[0].acc));
            end
        end
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            rr = 0;
        end else begin
            if (pop) void'(pend.pop_front());
            if (grant >= 0) begin
                r = ref_round(din[grant], mode[grant]);
                pend.push_back('{tag: grant, data: r[23:0], acc: r[24], avail: cyc + 2});
                rr = (grant + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int          nissue;
        logic [47:0] v;
        n_pass = 0; n_total = 0; n_fail = 0; rr = 0; cyc = 0;
        rst = 1'b0; req_valid = '0; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin din[i] = '0; mode[i] = 2'b00; end

        tick();
        tick();
        rst = 1'b1;

        // All requesters valid: grants rotate, tags follow two cycles later.
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin din[i] = 48'(i * 48'h1_000123); mode[i] = 2'(i); end
        for (int i = 0; i < 7; i++) begin
            if (i == 5) req_valid = 4'b0000;
            tick();
            if (i < 5) chk("q32_grant", 64'(obs_ready), 64'(1 << (i % 4)));
            if (i >= 2) begin
                chk("q32_res_valid", 64'(obs_rv), 1);
                chk("q32_tag_order", 64'(obs_tag), 64'((i - 2) % 4));
            end
        end
        tick();

        // Exact tie, odd upper half: round to even.
        din[0] = 48'h000001_800000; mode[0] = 2'b11; req_valid = 4'b0001;
        tick();
        chk("q30_grant", 64'(obs_ready), 64'b0001);
        req_valid = 4'b0000;
        tick();
        chk("q30_not_early", 64'(obs_rv), 0);
        tick();
        chk("q30_valid", 64'(obs_rv), 1);
        chk("q30_tag", 64'(obs_tag), 0);
        chk("q30_data", 64'(obs_data), 64'h000002);
        chk("q30_acc", 64'(obs_acc), 0);

        din[2] = 48'h000005_000000; mode[2] = 2'b00; req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        chk("q31_valid", 64'(obs_rv), 1);
        chk("q31_tag", 64'(obs_tag), 2);
        chk("q31_data", 64'(obs_data), 64'h000005);
        chk("q31_acc", 64'(obs_acc), 1);
        tick();

        // Consumer stalled: two issues fill the buffer, then issue resumes on the first pop.
        res_ready = 1'b0; req_valid = 4'b0011; nissue = 0;
        repeat (4) begin
            tick();
            if (obs_ready != 4'b0) nissue++;
        end
        chk("q33_issues", 64'(nissue), 2);
        chk("q33_ready_low", 64'(obs_ready), 0);
        chk("q33_busy", 64'(busy), 1);
        res_ready = 1'b1;
        tick();
        chk("q33_pop", 64'(obs_rv), 1);
        chk("q33_resume", 64'(obs_ready != 4'b0), 1);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Reset one cycle after an issue.
        req_valid = 4'b1111;
        tick();
        #1 rst = 1'b0;
        #1;
        chk("q34_req_ready", 64'(req_ready), 0);
        chk("q34_res_valid", 64'(res_valid), 0);
        chk("q34_busy", 64'(busy), 0);
        chk("q34_res_data", 64'(res_data), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("q34_rr_restart", 64'(obs_ready), 64'b0001);
        chk("q34_no_stale0", 64'(obs_rv), 0);
        req_valid = 4'b0000;
        tick();
        chk("q34_no_stale1", 64'(obs_rv), 0);
        repeat (3) tick();

        // Randomized traffic with tie/sticky corner values and occasional resets.
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                v = 48'({$urandom, $urandom});
                case ($urandom_range(0, 5))
                    0: v[23:0] = 24'h000000;
                    1: v[23:0] = 24'h800000;
                    2: v[23:0] = 24'h7fffff;
                    3: v[23:0] = 24'h800001;
                    4: v[47:24] = 24'hffffff;
                    default: ;
                endcase
                din[i]  = v;
                mode[i] = 2'($urandom);
            end
            rst = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst = 1'b1;
        req_valid = 4'b0000;
        res_ready = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 SHALL have parameter IS_DOUBLE, default 0, meaning 0 = single-precision widths (DIN_W 48, DOUT_W 24) and 1 = double-precision widths (DIN_W 106, DOUT_W 53).
REQ-002 SHALL have parameter N_REQ, default 4, meaning the number of requesters (legal range 2..8); TAG_W = clog2(N_REQ).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester request valid.
REQ-006 SHALL have port req_ready, output, N_REQ, per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_data, input, N_REQ*DIN_W, unrounded products; requester i occupies slice i.
REQ-008 SHALL have port req_mode, input, N_REQ*2, per-requester rounding mode (00 zero, 01 +inf, 10 -inf, 11 nearest-even).
REQ-009 SHALL have port res_valid, input-side handshake output, 1, result available.
REQ-010 SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have ports res_tag (output, TAG_W, originating requester index), res_data (output, DOUT_W, rounded value) and res_acc (output, 1, exact flag: 1 = no rounding needed).
REQ-012 SHALL have port busy, output, 1, high while any request is in flight or buffered.

Function
REQ-013 SHALL share one rounding unit (1-cycle registered latency) among N_REQ requesters.
REQ-014 SHALL keep occupancy = in-flight count (0/1) + result-buffer count (0..2), never exceeding 2.
REQ-015 SHALL allow an issue in a cycle only when (occupancy - pop_this_cycle) < 2, where pop = res_valid & res_ready.
REQ-016 SHALL grant round-robin: the first asserted req_valid at or after rr_ptr, wrapping from N_REQ-1 to 0; req_ready is high only for that index, combinationally from req_valid, rr_ptr and credit.
REQ-017 SHALL complete a transfer on req_valid[i] & req_ready[i]; then rr_ptr <= (i+1) mod N_REQ; rr_ptr SHALL be unchanged in cycles without a transfer.
REQ-018 SHALL drive the rounding unit with the granted slice and mode, and with all-zero data and mode 00 when no transfer occurs; the result of a no-transfer cycle SHALL be discarded.
REQ-019 SHALL register the granted index as the in-flight tag; the rounder output plus tag are pushed into a 2-entry FIFO in the following cycle.
REQ-020 SHALL present the FIFO head on res_*; latency is issue in cycle T -> res_valid earliest in T+2; results SHALL emerge in issue order.
REQ-021 SHALL sustain one issue per cycle while res_ready stays high.
REQ-022 SHALL hold res_tag, res_data and res_acc stable while res_valid & ~res_ready.
REQ-023 SHALL handle simultaneous push and pop at FIFO count 1 or 2 with the count unchanged; a pop at count 0 SHALL not occur.
REQ-024 SHALL drive busy = (occupancy != 0).

Reset
REQ-025 SHALL, on rst low, asynchronously clear rr_ptr, the in-flight valid bit, and the FIFO pointers and count; all outputs SHALL go to 0 (res_valid, res_tag, res_data, res_acc, busy, req_ready).
REQ-026 SHALL drive the rounding unit's synchronous active-high reset from ~rst; a reset mid-operation drops all in-flight and buffered results, and no result SHALL appear for them after release.
REQ-027 SHALL allow the first issue in the first clock after rst deasserts.

Structure
REQ-028 SHALL define the rounding-mode encodings (RM_ZERO, RM_POS_INF, RM_NEG_INF, RM_NEAR_EVEN) and the DIN_W/DOUT_W width functions in a shared package, round_pkg.
REQ-029 SHALL instantiate exactly one sub-module, rounding_module, with IS_DOUBLE passed through; the FIFO and arbiter are implemented inline.

Verification
REQ-030 SHALL cover: single precision, req0 data 48'h000001_800000, mode 11 -> res_tag 0, res_data 24'h000002, res_acc 0, two cycles after the issue.
REQ-031 SHALL cover: req2 data 48'h000005_000000, mode 00 -> res_data 24'h000005, res_acc 1, res_tag 2.
REQ-032 SHALL cover: all four req_valid held high, res_ready 1 -> grants 0,1,2,3,0 on consecutive cycles, and tags emerge in the same order from T+2 at one per cycle.
REQ-033 SHALL cover: res_ready 0 with req0..1 valid -> exactly 2 issues, then all req_ready low with busy 1; raise res_ready -> two pops, then issuing resumes in the same cycle as the first pop.
REQ-034 SHALL cover: rst asserted one cycle after an issue -> all outputs 0 immediately, no res_valid after release, and rr_ptr restarts at 0.
